// File: rtl/mux_scan_sequencer_pkg.sv
// Shared definitions for the mux scan sequencer: channel count, select width
// and the controller state encoding.
package mux_scan_sequencer_pkg;

    localparam int NUM_CH = 7;
    localparam int SEL_W  = 3;

    // Highest legal channel select; the scan wraps or finishes after it
    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_CH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // Step to the following channel select
    function automatic logic [SEL_W-1:0] next_channel(input logic [SEL_W-1:0] ch);
        return ch + SEL_W'(1);
    endfunction

endpackage

// File: rtl/mux_scan_sequencer_rate_divider.sv
// Dwell-time down-counter: reloads to DIV-1 whenever a channel is entered and
// flags expiry once it has counted down to zero.
module rate_divider #(
    parameter int DIV = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic reload,
    output logic expire
);

    localparam logic [15:0] RELOAD_VAL = 16'(DIV - 1);

    logic [15:0] count;

    // Reload on channel entry, otherwise count down and park at zero
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= 16'd0;
        end else if (reload) begin
            count <= RELOAD_VAL;
        end else if (count != 16'd0) begin
            count <= count - 16'd1;
        end
    end

    assign expire = (count == 16'd0);

endmodule

// File: rtl/mux_scan_sequencer.sv
// Steps a downstream 7:1 mux through channels 0..6, holding each for DIV
// cycles, with an optional continuous-loop mode and a held pattern register.
module mux_scan_sequencer
    import mux_scan_sequencer_pkg::*;
#(
    parameter int DIV     = 4,
    parameter bit LOOP_EN = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [6:0]       pattern_in,
    input  logic             start,
    input  logic             loop,
    output logic [6:0]       pattern,
    output logic [SEL_W-1:0] func,
    output logic             chan_start,
    output logic             busy,
    output logic             done
);

    state_t           state;
    state_t           next_state;
    logic [SEL_W-1:0] next_func;
    logic [6:0]       next_pattern;
    logic             next_chan_start;
    logic             next_busy;
    logic             next_done;
    logic             reload;
    logic             expire;
    logic             restart_loop;

    rate_divider #(
        .DIV(DIV)
    ) u_rate_divider (
        .clock (clock),
        .reset (reset),
        .reload(reload),
        .expire(expire)
    );

    assign restart_loop = LOOP_EN && loop;

    // Next-state and next-output decode; outputs are registered below so
    // nothing combinational reaches the ports
    always_comb begin
        next_state      = state;
        next_func       = func;
        next_pattern    = pattern;
        next_chan_start = 1'b0;
        next_done       = 1'b0;
        reload          = 1'b0;

        if (load && (state != SCAN)) begin
            next_pattern = pattern_in;
        end

        case (state)
            IDLE: begin
                if (start) begin
                    next_state      = SCAN;
                    next_func       = '0;
                    next_chan_start = 1'b1;
                    reload          = 1'b1;
                end
            end
            SCAN: begin
                if (expire) begin
                    if (func != LAST_CH) begin
                        next_func       = next_channel(func);
                        next_chan_start = 1'b1;
                        reload          = 1'b1;
                    end else if (restart_loop) begin
                        next_func       = '0;
                        next_chan_start = 1'b1;
                        reload          = 1'b1;
                    end else begin
                        next_state = DONE;
                        next_done  = 1'b1;
                    end
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase

        next_busy = (next_state == SCAN);
    end

    // State and registered outputs; reset wins over load and start
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            pattern    <= '0;
            func       <= '0;
            chan_start <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= next_state;
            pattern    <= next_pattern;
            func       <= next_func;
            chan_start <= next_chan_start;
            busy       <= next_busy;
            done       <= next_done;
        end
    end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Bench for mux_scan_sequencer: three instances (DIV=4, DIV=1, DIV=2 with
// looping enabled) share one stimulus stream; a cycle-position model predicts
// every output each cycle, and directed scenarios pin literal timings.
module tb_mux_scan_sequencer;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       load = 1'b0;
    logic [6:0] patternIn = 7'd0;
    logic       start = 1'b0;
    logic       loop = 1'b0;

    logic [6:0] pat [3];
    logic [2:0] fn  [3];
    logic       cs  [3];
    logic       bsy [3];
    logic       dn  [3];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int doneAt [3];

    int  mDiv    [3] = '{4, 1, 2};
    bit  mLoopEn [3] = '{1'b0, 1'b0, 1'b1};
    logic [6:0] mPat [3];
    int  mFunc [3];
    bit  mCs   [3];
    bit  mBusy [3];
    bit  mDone [3];
    int  mPos  [3];
    bit  modelValid = 1'b0;

    mux_scan_sequencer #(.DIV(4), .LOOP_EN(1'b0)) dut4 (
        .clock(clock), .reset(reset), .load(load), .pattern_in(patternIn),
        .start(start), .loop(loop), .pattern(pat[0]), .func(fn[0]),
        .chan_start(cs[0]), .busy(bsy[0]), .done(dn[0])
    );

    mux_scan_sequencer #(.DIV(1), .LOOP_EN(1'b0)) dut1 (
        .clock(clock), .reset(reset), .load(load), .pattern_in(patternIn),
        .start(start), .loop(loop), .pattern(pat[1]), .func(fn[1]),
        .chan_start(cs[1]), .busy(bsy[1]), .done(dn[1])
    );

    mux_scan_sequencer #(.DIV(2), .LOOP_EN(1'b1)) dut2 (
        .clock(clock), .reset(reset), .load(load), .pattern_in(patternIn),
        .start(start), .loop(loop), .pattern(pat[2]), .func(fn[2]),
        .chan_start(cs[2]), .busy(bsy[2]), .done(dn[2])
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic ld, input logic [6:0] pin,
                                 input logic st, input logic lp);
        reset     = r;
        load      = ld;
        patternIn = pin;
        start     = st;
        loop      = lp;
    endtask

    task automatic tick();
        @(negedge clock);
        cyc++;
        for (int i = 0; i < 3; i++) begin
            if (dn[i] === 1'b1 && doneAt[i] < 0) doneAt[i] = cyc;
        end
    endtask

    task automatic clearDone();
        cyc = 0;
        for (int i = 0; i < 3; i++) doneAt[i] = -1;
    endtask

    task automatic runTo(input int lastCycle);
        while (cyc < lastCycle) tick();
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 1'b0, 7'd0, 1'b0, 1'b0);
        tick();
        tick();
        applyStimulus(1'b0, 1'b0, 7'd0, 1'b0, 1'b0);
    endtask

    // Scan-position model: position counts cycles since the scan started, so
    // the channel is position/DIV and a new channel begins when position%DIV==0
    always @(posedge clock) begin
        bit wasDone;
        for (int i = 0; i < 3; i++) begin
            if (reset) begin
                mPat[i]  = 7'd0;
                mFunc[i] = 0;
                mCs[i]   = 1'b0;
                mBusy[i] = 1'b0;
                mDone[i] = 1'b0;
                mPos[i]  = 0;
                modelValid = 1'b1;
            end else begin
                wasDone  = mDone[i];
                mDone[i] = 1'b0;
                mCs[i]   = 1'b0;
                if (!mBusy[i] && load) mPat[i] = patternIn;
                if (mBusy[i]) begin
                    mPos[i]++;
                    if (mPos[i] == 7 * mDiv[i]) begin
                        if (mLoopEn[i] && loop) begin
                            mPos[i]  = 0;
                            mFunc[i] = 0;
                            mCs[i]   = 1'b1;
                        end else begin
                            mBusy[i] = 1'b0;
                            mDone[i] = 1'b1;
                        end
                    end else begin
                        mFunc[i] = mPos[i] / mDiv[i];
                        mCs[i]   = (mPos[i] % mDiv[i]) == 0;
                    end
                end else if (!wasDone && start) begin
                    mBusy[i] = 1'b1;
                    mPos[i]  = 0;
                    mFunc[i] = 0;
                    mCs[i]   = 1'b1;
                end
            end
        end
    end

    // Every-cycle comparison of all three instances against the model
    always @(negedge clock) begin
        if (modelValid) begin
            for (int i = 0; i < 3; i++) begin
                checkOutput($sformatf("dut%0d pattern", i), int'(pat[i]), int'(mPat[i]));
                checkOutput($sformatf("dut%0d func", i), int'(fn[i]), mFunc[i]);
                checkOutput($sformatf("dut%0d chan_start", i), int'(cs[i]), int'(mCs[i]));
                checkOutput($sformatf("dut%0d busy", i), int'(bsy[i]), int'(mBusy[i]));
                checkOutput($sformatf("dut%0d done", i), int'(dn[i]), int'(mDone[i]));
            end
        end
    end

    // Directed scenarios with literal expectations
    initial begin
        logic [6:0] muxSeq;
        logic [6:0] expSeq;
        int nSeq;
        int csCount;
        nSeq = 0;
        csCount = 0;
        muxSeq = 7'd0;
        expSeq = 7'b1010101;
        clearDone();

        // Reset state, then load 1010101 and scan
        doReset();
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("reset dut%0d pattern", i), int'(pat[i]), 0);
            checkOutput($sformatf("reset dut%0d func", i), int'(fn[i]), 0);
            checkOutput($sformatf("reset dut%0d busy", i), int'(bsy[i]), 0);
        end
        applyStimulus(1'b0, 1'b1, 7'b1010101, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 7'd0, 1'b1, 1'b0);
        clearDone();
        tick();
        applyStimulus(1'b0, 1'b0, 7'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("start dut%0d busy", i), int'(bsy[i]), 1);
            checkOutput($sformatf("start dut%0d chan_start", i), int'(cs[i]), 1);
        end
        while (cyc < 40) begin
            if (cs[0] === 1'b1 && nSeq < 7) begin
                muxSeq[nSeq] = pat[0][fn[0]];
                nSeq++;
            end
            if (cyc <= 7 && cs[1] === 1'b1) csCount++;
            tick();
        end
        checkOutput("div4 channel count", nSeq, 7);
        checkOutput("div4 mux sequence", int'(muxSeq), int'(expSeq));
        checkOutput("div1 consecutive chan_start", csCount, 7);
        checkOutput("div4 done cycle", doneAt[0], 29);
        checkOutput("div1 done cycle", doneAt[1], 8);
        checkOutput("div2 done cycle", doneAt[2], 15);
        checkOutput("div4 func held after done", int'(fn[0]), 6);

        // Load and start while scanning are both ignored
        doReset();
        applyStimulus(1'b0, 1'b0, 7'd0, 1'b1, 1'b0);
        clearDone();
        tick();
        applyStimulus(1'b0, 1'b0, 7'd0, 1'b0, 1'b0);
        runTo(7);
        checkOutput("div2 func before load", int'(fn[2]), 3);
        applyStimulus(1'b0, 1'b1, 7'h7F, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 7'd0, 1'b0, 1'b0);
        runTo(11);
        checkOutput("div2 func before start", int'(fn[2]), 5);
        applyStimulus(1'b0, 1'b0, 7'd0, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 7'd0, 1'b0, 1'b0);
        runTo(40);
        checkOutput("div2 pattern frozen", int'(pat[2]), 0);
        checkOutput("div2 done ignoring start", doneAt[2], 15);

        // Looping on the DIV=2 instance; the others ignore loop
        doReset();
        applyStimulus(1'b0, 1'b0, 7'd0, 1'b1, 1'b1);
        clearDone();
        tick();
        applyStimulus(1'b0, 1'b0, 7'd0, 1'b0, 1'b1);
        runTo(15);
        checkOutput("loop func wrap", int'(fn[2]), 0);
        checkOutput("loop chan_start", int'(cs[2]), 1);
        checkOutput("loop busy", int'(bsy[2]), 1);
        applyStimulus(1'b0, 1'b0, 7'd0, 1'b0, 1'b0);
        runTo(40);
        checkOutput("loop done second pass", doneAt[2], 29);
        checkOutput("loop ignored div4", doneAt[0], 29);
        checkOutput("loop ignored div1", doneAt[1], 8);

        // Mid-scan reset, then start in the first cycle after release
        doReset();
        applyStimulus(1'b0, 1'b1, 7'b0110011, 1'b1, 1'b0);
        clearDone();
        tick();
        applyStimulus(1'b0, 1'b0, 7'd0, 1'b0, 1'b0);
        runTo(9);
        checkOutput("div2 func before reset", int'(fn[2]), 4);
        checkOutput("div2 pattern before reset", int'(pat[2]), 7'b0110011);
        applyStimulus(1'b1, 1'b0, 7'd0, 1'b0, 1'b0);
        tick();
        checkOutput("abort func", int'(fn[2]), 0);
        checkOutput("abort busy", int'(bsy[2]), 0);
        checkOutput("abort pattern", int'(pat[2]), 0);
        checkOutput("abort done", int'(dn[2]), 0);
        checkOutput("abort no done div2", doneAt[2], -1);
        checkOutput("abort no done div4", doneAt[0], -1);
        applyStimulus(1'b0, 1'b0, 7'd0, 1'b1, 1'b0);
        clearDone();
        tick();
        applyStimulus(1'b0, 1'b0, 7'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("restart dut%0d busy", i), int'(bsy[i]), 1);
        end
        runTo(40);
        checkOutput("restart div4 done", doneAt[0], 29);
        checkOutput("restart div1 done", doneAt[1], 8);
        checkOutput("restart div2 done", doneAt[2], 15);

        // Same-cycle load and start in IDLE
        doReset();
        applyStimulus(1'b0, 1'b1, 7'b0000001, 1'b1, 1'b0);
        clearDone();
        tick();
        applyStimulus(1'b0, 1'b0, 7'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("load+start dut%0d pattern", i), int'(pat[i]), 1);
            checkOutput($sformatf("load+start dut%0d func", i), int'(fn[i]), 0);
            checkOutput($sformatf("load+start dut%0d chan_start", i), int'(cs[i]), 1);
        end
        runTo(40);
        checkOutput("load+start div4 done", doneAt[0], 29);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mux_scan_sequencer.md
MUX_SCAN_SEQUENCER -- requirements
Module: mux_scan_sequencer

Interface
REQ-001 Parameter DIV, default 4, means clock cycles each channel is held; legal range 1..65535.
REQ-002 Parameter LOOP_EN, default 0; when 1, the loop input is honoured, when 0, loop is ignored.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  reset is synchronous and active-high.
REQ-005 load  input  1  capture pattern_in into the held pattern register.
REQ-006 pattern_in  input  7  new channel pattern.
REQ-007 start  input  1  one-cycle request to begin a scan of channels 0..6.
REQ-008 loop  input  1  sampled at channel-6 expiry; 1 = restart at channel 0 instead of finishing.
REQ-009 pattern  output  7  held pattern register; drives the data inputs of the downstream 7:1 mux.
REQ-010 func  output  3  channel select for the downstream 7:1 mux; only values 0..6 ever appear.
REQ-011 chan_start  output  1  one-cycle pulse in the first cycle that a new func value is valid.
REQ-012 busy  output  1  high while scanning.
REQ-013 done  output  1  one-cycle pulse when a non-looping scan completes.

Function
REQ-014 FSM states: IDLE, SCAN, DONE.
- IDLE -> SCAN on start.
- SCAN -> DONE at channel-6 expiry with (LOOP_EN=0 or loop=0).
- SCAN -> SCAN at channel-6 expiry with LOOP_EN=1 and loop=1; func returns to 0.
- DONE -> IDLE unconditionally after one cycle.
REQ-015 start in IDLE at edge n gives, at cycle n+1: busy=1, func=0, chan_start=1.
REQ-016 Each channel is held exactly DIV cycles; then func increments by 1 with chan_start=1 in the first cycle of the new channel.
REQ-017 Hold timing is set by a down-counter: loaded with DIV-1 at every channel entry; channel expires when the counter is 0; DIV=1 therefore advances every cycle.
REQ-018 Non-looping scan timing: DONE state, done=1, busy=0 at cycle n+1+7*DIV; done lasts exactly one cycle.
REQ-019 func holds its last value (6) in DONE and IDLE after a completed scan; func=0 only after reset or at scan start.
REQ-020 load in IDLE or DONE updates pattern on the next edge; load while busy=1 is ignored, so pattern is frozen during a scan.
REQ-021 load and start in the same IDLE cycle: the new pattern is captured and the scan starts in the same edge, so channel 0 uses the new pattern.
REQ-022 start while busy=1 or in DONE is ignored; it is neither queued nor restarts the scan.
REQ-023 func never takes value 7 in any state.
REQ-024 chan_start and done are never high together.

Reset
REQ-025 On reset at an edge, the next cycle has: state=IDLE, pattern=0, func=0, busy=0, done=0, chan_start=0, divider counter=0.
REQ-026 Reset has priority over load and start, and aborts an in-progress scan without pulsing done.
REQ-027 start asserted in the first cycle after reset is released is accepted normally.

Structure
REQ-028 A shared package holds NUM_CH=7, SEL_W=3, and the state encodings IDLE=2'd0, SCAN=2'd1, DONE=2'd2.
REQ-029 The down-counter is a sub-module rate_divider with parameter DIV, inputs clock, reset, reload, and output expire; mux_scan_sequencer instantiates it once.
REQ-030 No combinational path exists from inputs to outputs; all outputs are registered.

Verification
REQ-031 DIV=4: load 7'b1010101, then start -> busy at +1, func 0..6 each held 4 cycles, done pulse at +29, busy=0 at +29; a downstream mux output follows 1,0,1,0,1,0,1.
REQ-032 DIV=1: start -> func 0,1,2,3,4,5,6 on consecutive cycles, chan_start high for 7 cycles, done at +8.
REQ-033 DIV=2: load 7'h7F during SCAN at func=3 -> pattern unchanged; start at func=5 -> ignored; done at +15.
REQ-034 LOOP_EN=1, loop=1, DIV=2: after func=6 expires -> func=0 with chan_start=1 and no done pulse; drop loop before next expiry -> done after the second pass.
REQ-035 Reset asserted at func=4 mid-scan -> next cycle func=0, busy=0, pattern=0, no done pulse; a start 1 cycle after reset release scans normally.
REQ-036 Same-cycle load 7'b0000001 + start in IDLE -> func=0 with pattern=7'b0000001 at +1.
